// File: rtl/ctrl_bus_pkg.sv
// Shared address map, bad-address read value, FSM state and register-select encodings.
// The register bank and its address decoder both import this package.
package ctrl_bus_pkg;

    localparam logic [15:0] ADDR_ID        = 16'h0000;
    localparam logic [15:0] ADDR_SCRATCH   = 16'h0001;
    localparam logic [15:0] ADDR_PULSE     = 16'h0002;
    localparam logic [15:0] ADDR_UPTIME    = 16'h0003;
    localparam logic [15:0] ADDR_TXCNT     = 16'h0004;
    localparam logic [15:0] ADDR_CTRL_BASE = 16'h0010;
    localparam logic [15:0] ADDR_STAT_BASE = 16'h0020;

    localparam logic [31:0] BADADDR_VALUE  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_NONE    = 3'd0,
        SEL_ID      = 3'd1,
        SEL_SCRATCH = 3'd2,
        SEL_PULSE   = 3'd3,
        SEL_UPTIME  = 3'd4,
        SEL_TXCNT   = 3'd5,
        SEL_CTRL    = 3'd6,
        SEL_STAT    = 3'd7
    } reg_sel_t;

endpackage

// File: rtl/ctrl_bus_decode.sv
// Address decode: register select, bank index, read-only flag and valid flag.
// Purely combinational, no latency and no backpressure.
module ctrl_bus_decode
    import ctrl_bus_pkg::*;
#(
    parameter int N_CTRL = 4,
    parameter int N_STAT = 4
) (
    input  logic [15:0] address,
    output logic [2:0]  sel,
    output logic [3:0]  idx,
    output logic        ro,
    output logic        valid
);

    reg_sel_t sel_e;

    always_comb begin
        sel_e = SEL_NONE;
        ro    = 1'b0;
        if (address == ADDR_ID) begin
            sel_e = SEL_ID;
            ro    = 1'b1;
        end else if (address == ADDR_SCRATCH) begin
            sel_e = SEL_SCRATCH;
        end else if (address == ADDR_PULSE) begin
            sel_e = SEL_PULSE;
        end else if (address == ADDR_UPTIME) begin
            sel_e = SEL_UPTIME;
        end else if (address == ADDR_TXCNT) begin
            sel_e = SEL_TXCNT;
            ro    = 1'b1;
        end else if (address[15:4] == ADDR_CTRL_BASE[15:4] && int'(address[3:0]) < N_CTRL) begin
            sel_e = SEL_CTRL;
        end else if (address[15:4] == ADDR_STAT_BASE[15:4] && int'(address[3:0]) < N_STAT) begin
            sel_e = SEL_STAT;
            ro    = 1'b1;
        end
    end

    assign sel   = sel_e;
    assign idx   = address[3:0];
    assign valid = (sel_e != SEL_NONE);

endmodule

// File: rtl/ctrl_bus_regbank.sv
// Control-link register bank: ID, scratch, pulse, uptime, transaction count, control and status words.
// Ack 2 cycles after the strobe edge; held until strobe is seen low (four-phase handshake, no other backpressure).
module ctrl_bus_regbank
    import ctrl_bus_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'hC0DE_0001,
    parameter int          N_CTRL   = 4,
    parameter int          N_STAT   = 4
) (
    input  logic                  byte_clk,
    input  logic                  reset,
    input  logic                  strobe,
    input  logic [15:0]           address,
    input  logic                  requestIsWrite,
    input  logic [31:0]           dataIn,
    input  logic                  linkOk,
    output logic                  ack,
    output logic [31:0]           dataOut,
    output logic [32*N_CTRL-1:0]  ctrl_regs,
    input  logic [32*N_STAT-1:0]  stat_in,
    output logic [31:0]           pulse_out
);

    localparam int CIW = (N_CTRL > 1) ? $clog2(N_CTRL) : 1;
    localparam int SIW = (N_STAT > 1) ? $clog2(N_STAT) : 1;

    state_t      state, state_nxt;
    logic        strobe_d;
    logic [15:0] req_addr;
    logic        req_wr;
    logic [31:0] req_data;
    logic [31:0] scratch, uptime, txcnt, rd_data;
    logic [31:0] ctrl_q [N_CTRL];
    logic [31:0] stat_w [N_STAT];
    logic        do_latch, do_exec, do_ack, ack_drop, wr_en;
    logic [2:0]  dec_sel;
    logic [3:0]  dec_idx;
    logic        dec_ro, dec_valid;
    logic        unused_idx_bits;

    ctrl_bus_decode #(.N_CTRL(N_CTRL), .N_STAT(N_STAT)) u_decode (
        .address (req_addr),
        .sel     (dec_sel),
        .idx     (dec_idx),
        .ro      (dec_ro),
        .valid   (dec_valid)
    );

    assign unused_idx_bits = ^dec_idx;

    for (genvar k = 0; k < N_CTRL; k++) begin : g_ctrl
        assign ctrl_regs[32*k +: 32] = ctrl_q[k];
    end
    for (genvar k = 0; k < N_STAT; k++) begin : g_stat
        assign stat_w[k] = stat_in[32*k +: 32];
    end

    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            strobe_d <= 1'b0;
        end else begin
            state    <= state_nxt;
            strobe_d <= strobe;
        end
    end

    // A dropped link aborts the handshake from any state.
    always_comb begin
        state_nxt = state;
        if (!linkOk) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (strobe && !strobe_d) state_nxt = ST_EXEC;
                ST_EXEC: state_nxt = ST_ACK;
                ST_ACK:  if (!strobe) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // A write sitting in EXEC commits even if the link drops in that cycle.
    always_comb begin
        do_latch = (state == ST_IDLE) && linkOk && strobe && !strobe_d;
        do_exec  = (state == ST_EXEC);
        do_ack   = do_exec && linkOk;
        ack_drop = !linkOk || ((state == ST_ACK) && !strobe);
        wr_en    = do_exec && req_wr && dec_valid && !dec_ro;
    end

    always_comb begin
        rd_data = BADADDR_VALUE;
        case (dec_sel)
            SEL_ID:      rd_data = ID_VALUE;
            SEL_SCRATCH: rd_data = scratch;
            SEL_PULSE:   rd_data = 32'h0;
            SEL_UPTIME:  rd_data = uptime;
            SEL_TXCNT:   rd_data = txcnt;
            SEL_CTRL:    rd_data = ctrl_q[dec_idx[CIW-1:0]];
            SEL_STAT:    rd_data = stat_w[dec_idx[SIW-1:0]];
            default:     rd_data = BADADDR_VALUE;
        endcase
    end

    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            req_addr <= 16'h0;
            req_wr   <= 1'b0;
            req_data <= 32'h0;
        end else if (do_latch) begin
            req_addr <= address;
            req_wr   <= requestIsWrite;
            req_data <= dataIn;
        end
    end

    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            ack     <= 1'b0;
            dataOut <= 32'h0;
            txcnt   <= 32'h0;
        end else begin
            if (do_ack) begin
                ack     <= 1'b1;
                dataOut <= req_wr ? req_data : rd_data;
                txcnt   <= txcnt + 32'd1;
            end else if (ack_drop) begin
                ack <= 1'b0;
            end
        end
    end

    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            scratch   <= 32'h0;
            uptime    <= 32'h0;
            pulse_out <= 32'h0;
            for (int k = 0; k < N_CTRL; k++) ctrl_q[k] <= 32'h0;
        end else begin
            uptime    <= (wr_en && dec_sel == SEL_UPTIME) ? 32'h0 : uptime + 32'd1;
            pulse_out <= (wr_en && dec_sel == SEL_PULSE) ? req_data : 32'h0;
            if (wr_en && dec_sel == SEL_SCRATCH) scratch <= req_data;
            if (wr_en && dec_sel == SEL_CTRL) ctrl_q[dec_idx[CIW-1:0]] <= req_data;
        end
    end

endmodule

// File: doc/ctrl_bus_regbank.md
# ctrl_bus_regbank

Register bank that consumes the decoded request stream of the control-link slave (strobe, address, write flag, write data) and answers it with ack and read data over a four-phase handshake. It sits directly downstream of the control link on `byte_clk`. It is the single place where run-control software reads IDs, counters and status and writes control words and one-shot pulses.

## Interface
- `ID_VALUE`, 32'hC0DE_0001: constant returned at address 0x0000.
- `N_CTRL`, 4: number of RW control registers (1..16).
- `N_STAT`, 4: number of RO status inputs (1..16).
- `byte_clk`  in  1: the only clock.
- `reset`  in  1: asynchronous, active-high.
- `strobe`  in  1: request level from the link; its rising edge starts a transaction.
- `address`  in  16: register address, valid when `strobe` rises.
- `requestIsWrite`  in  1: 1 = write, 0 = read, valid when `strobe` rises.
- `dataIn`  in  32: write data, valid when `strobe` rises.
- `linkOk`  in  1: link status.
- `ack`  out  1: transaction-complete flag back to the link.
- `dataOut`  out  32: read data, or the echoed write data.
- `ctrl_regs`  out  32*N_CTRL: control words, register k at bits [32k+31:32k].
- `stat_in`  in  32*N_STAT: status words, sampled on read.
- `pulse_out`  out  32: one-cycle pulses.

## Operation
- FSM states: IDLE, EXEC, ACK.
- IDLE -> EXEC when `strobe`=1 and `strobe_d`=0. `strobe_d` is `strobe` registered every cycle. On that edge, latch `address`, `requestIsWrite` and `dataIn`.
- EXEC -> ACK unconditionally. On this edge: apply the write or register the read mux into `dataOut`, set `ack`<=1 and increment the transaction counter.
- ACK: hold `ack`=1 while `strobe`=1. When `strobe` is sampled 0, set `ack`<=0 and go to IDLE.
- Address map:
  - 0x0000: ID, RO.
  - 0x0001: scratch, RW, reset 0.
  - 0x0002: pulse, WO. A write drives `pulse_out`=data for exactly one cycle. Reads return 0.
  - 0x0003: uptime, a 32-bit free-running counter that wraps. Any write clears it.
  - 0x0004: transaction count, RO, wraps at 2^32.
  - 0x0010..0x0010+N_CTRL-1: control, RW.
  - 0x0020..0x0020+N_STAT-1: status, RO.
- Writes to RO registers are ignored. They are still acked and `dataOut` echoes the write data.
- An unmapped address reads 32'hDEAD_BEEF. A write to it is ignored but acked.
- On a write, `dataOut` is set to the write data. `dataOut` otherwise holds its last value.
- `linkOk`=0 in any state: `ack`<=0 and the FSM goes to IDLE. A write already in EXEC is still committed. `strobe_d` keeps tracking `strobe`.
- Reset values: `ack`=0, `dataOut`=0, `ctrl_regs`=0, `pulse_out`=0, scratch=0, both counters=0, state IDLE, `strobe_d`=0.

## Timing
- Strobe rising edge sampled at edge N. Request latched at N, EXEC during N..N+1. At N+1: `ack`=1, `dataOut` valid, write effects visible, pulse high. At N+2: pulse low.
- Read-to-ack latency is 2 cycles. `dataOut` is stable for the whole time `ack` is high.
- Strobe high for a single cycle: the transaction still completes. `ack` is high for one cycle (ACK sees `strobe`=0) and the FSM returns to IDLE.
- A new rising edge is only accepted in IDLE. Edges during EXEC or ACK are impossible under the handshake and are ignored.
- Uptime write clear coinciding with an increment: clear wins, value 0 at N+1.
- Transaction-count read: returns the value before the increment from the same transaction.
- Async reset mid-transaction: every output goes to its reset value immediately. No write is committed unless EXEC had already completed.

## Structure
- Package `ctrl_bus_pkg` holds: address constants (ADDR_ID, ADDR_SCRATCH, ADDR_PULSE, ADDR_UPTIME, ADDR_TXCNT, ADDR_CTRL_BASE, ADDR_STAT_BASE), BADADDR_VALUE, and the FSM state encoding.
- Sub-module `ctrl_bus_decode`: combinational address decode giving a register select, a RO flag and a valid flag. Everything else stays in the top.

## Test plan
- Reset, then read 0x0000 -> `ack` rises 2 cycles after the strobe edge, `dataOut`=32'hC0DE_0001. `ack` falls the cycle after strobe is sampled low.
- Write 32'h1234_5678 to 0x0011, then read 0x0011 -> `ctrl_regs`[63:32]=32'h1234_5678 from N+1, read returns the same value.
- Write 32'h0000_0005 to 0x0002 -> `pulse_out`=5 for exactly one cycle, 0 afterwards. Read 0x0002 returns 0.
- Read 0x0100 -> 32'hDEAD_BEEF. Write 0x0000 -> ID unchanged, acked, `dataOut` echoes the write data.
- Write 0x0003 on the same edge as an uptime increment -> reads just after return a small value counting from 0. Then 3 transactions -> 0x0004 increases by 3.
- Assert `reset` during EXEC of a write to 0x0010 -> `ctrl_regs`=0, `ack`=0. Also drop `linkOk` during ACK -> `ack` falls next cycle and the FSM is back in IDLE.
